// File: rtl/reg_native_arb.sv
// Round-robin arbiter sharing one reg_native downstream port between N_REQ upstream masters.
// Optional downstream timeout is enabled by defining REG_NATIVE_ARB_TIMEOUT_EN.
module reg_native_arb #(
    parameter int N_REQ          = 2,
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            up_req_vld,
    output logic [N_REQ-1:0]            up_req_rdy,
    input  logic [N_REQ-1:0]            up_wr_en,
    input  logic [N_REQ-1:0]            up_rd_en,
    input  logic [N_REQ*ADDR_WIDTH-1:0] up_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] up_wr_data,
    output logic [N_REQ-1:0]            up_ack_vld,
    input  logic [N_REQ-1:0]            up_ack_rdy,
    output logic [DATA_WIDTH-1:0]       up_rd_data,
`ifdef REG_NATIVE_ARB_TIMEOUT_EN
    output logic                        up_err,
`endif
    output logic                        req_vld,
    input  logic                        req_rdy,
    output logic                        wr_en,
    output logic                        rd_en,
    output logic [ADDR_WIDTH-1:0]       addr,
    output logic [DATA_WIDTH-1:0]       wr_data,
    input  logic                        ack_vld,
    output logic                        ack_rdy,
    input  logic [DATA_WIDTH-1:0]       rd_data,
    output logic [$clog2(N_REQ)-1:0]    grant_id,
    output logic                        busy
);
    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_RESP     = 2'd3
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [ID_W-1:0]       rr_ptr_r;
    logic [ID_W-1:0]       grant_r;
    logic [ID_W-1:0]       winner_s;
    logic [ID_W-1:0]       idx_s;
    logic                  any_vld_s;
    logic                  hit_s;
    logic                  accept_s;
    logic                  ack_take_s;
    logic                  to_fire_s;
    logic                  timeout_s;
    logic                  wr_en_r;
    logic                  rd_en_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] wr_data_r;
    logic [DATA_WIDTH-1:0] rd_data_r;

    // Round-robin search starting one past the last grant; the first hit wins.
    always_comb begin
        winner_s  = rr_ptr_r;
        any_vld_s = 1'b0;
        idx_s     = rr_ptr_r;
        hit_s     = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx_s     = ID_W'((int'(rr_ptr_r) + i) % N_REQ);
            hit_s     = up_req_vld[idx_s] & ~any_vld_s;
            winner_s  = hit_s ? idx_s : winner_s;
            any_vld_s = any_vld_s | hit_s;
        end
    end

    assign accept_s = (state_r == ST_IDLE) && any_vld_s;

    // One-hot accept pulse to the winner while idle.
    always_comb begin
        up_req_rdy = {N_REQ{1'b0}};
        if (accept_s) begin
            up_req_rdy[winner_s] = 1'b1;
        end else begin
            up_req_rdy = {N_REQ{1'b0}};
        end
    end

    // Next-state decode; a real handshake always takes precedence over the timeout.
    always_comb begin
        state_nxt_s = state_r;
        ack_take_s  = 1'b0;
        to_fire_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_vld_s) state_nxt_s = ST_REQ;
                else           state_nxt_s = ST_IDLE;
            end
            ST_REQ: begin
                if (req_rdy) begin
                    state_nxt_s = ST_WAIT_ACK;
                end else if (timeout_s) begin
                    state_nxt_s = ST_RESP;
                    to_fire_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT_ACK: begin
                if (ack_vld) begin
                    state_nxt_s = ST_RESP;
                    ack_take_s  = 1'b1;
                end else if (timeout_s) begin
                    state_nxt_s = ST_RESP;
                    to_fire_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT_ACK;
                end
            end
            ST_RESP: begin
                if (up_ack_rdy[grant_r]) state_nxt_s = ST_IDLE;
                else                     state_nxt_s = ST_RESP;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_nxt_s;
    end

    // Grant, pointer, downstream payload and response data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r  <= ID_W'(N_REQ - 1);
            grant_r   <= {ID_W{1'b0}};
            wr_en_r   <= 1'b0;
            rd_en_r   <= 1'b0;
            addr_r    <= {ADDR_WIDTH{1'b0}};
            wr_data_r <= {DATA_WIDTH{1'b0}};
            rd_data_r <= {DATA_WIDTH{1'b0}};
        end else begin
            if (accept_s) begin
                rr_ptr_r  <= winner_s;
                grant_r   <= winner_s;
                wr_en_r   <= up_wr_en[winner_s];
                rd_en_r   <= up_rd_en[winner_s];
                addr_r    <= up_addr[int'(winner_s)*ADDR_WIDTH +: ADDR_WIDTH];
                wr_data_r <= up_wr_data[int'(winner_s)*DATA_WIDTH +: DATA_WIDTH];
            end
            if (ack_take_s)     rd_data_r <= rd_data;
            else if (to_fire_s) rd_data_r <= {DATA_WIDTH{1'b1}};
        end
    end

`ifdef REG_NATIVE_ARB_TIMEOUT_EN
    logic [15:0] to_cnt_r;
    logic        up_err_r;

    // Cycles spent downstream; zero on the first REQ cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                                  to_cnt_r <= 16'd0;
        else if (state_r == ST_IDLE)                              to_cnt_r <= 16'd0;
        else if (state_r == ST_REQ || state_r == ST_WAIT_ACK)     to_cnt_r <= to_cnt_r + 16'd1;
        else                                                      to_cnt_r <= to_cnt_r;
    end

    assign timeout_s = (to_cnt_r == 16'(TIMEOUT_CYCLES - 1));

    // Error flag lives for exactly the RESP phase of a timed-out transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                               up_err_r <= 1'b0;
        else if (to_fire_s)                                    up_err_r <= 1'b1;
        else if (state_r == ST_RESP && up_ack_rdy[grant_r])    up_err_r <= 1'b0;
        else                                                   up_err_r <= up_err_r;
    end

    assign up_err = up_err_r;
`else
    assign timeout_s = 1'b0;
`endif

    // Upstream acknowledge routed to the granted requester only.
    always_comb begin
        up_ack_vld = {N_REQ{1'b0}};
        if (state_r == ST_RESP) begin
            up_ack_vld[grant_r] = 1'b1;
        end else begin
            up_ack_vld = {N_REQ{1'b0}};
        end
    end

    assign req_vld    = (state_r == ST_REQ);
    assign ack_rdy    = (state_r == ST_WAIT_ACK);
    assign busy       = (state_r != ST_IDLE);
    assign grant_id   = grant_r;
    assign wr_en      = wr_en_r;
    assign rd_en      = rd_en_r;
    assign addr       = addr_r;
    assign wr_data    = wr_data_r;
    assign up_rd_data = rd_data_r;

endmodule

// File: tb/tb_reg_native_arb.sv
// Directed self-checking bench for reg_native_arb (two requesters, zero-wait and backpressured downstream).
module tb_reg_native_arb;
    localparam int N  = 2;
    localparam int AW = 64;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    up_req_vld, up_req_rdy, up_wr_en, up_rd_en, up_ack_vld, up_ack_rdy;
    logic [N*AW-1:0] up_addr;
    logic [N*DW-1:0] up_wr_data;
    logic [DW-1:0]   up_rd_data;
    logic            req_vld, req_rdy, wr_en, rd_en, ack_vld, ack_rdy, busy;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wr_data, rd_data;
    logic [0:0]      grant_id;
`ifdef REG_NATIVE_ARB_TIMEOUT_EN
    logic            up_err;
`endif

    int          n_chk = 0;
    int          n_fail = 0;
    int          ds_req_cnt = 0;
    int          up_ack_cnt = 0;
    logic        ack1_seen = 1'b0;
    logic [31:0] mreg = 32'h0;

    reg_native_arb #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .up_req_vld(up_req_vld), .up_req_rdy(up_req_rdy),
        .up_wr_en(up_wr_en), .up_rd_en(up_rd_en),
        .up_addr(up_addr), .up_wr_data(up_wr_data),
        .up_ack_vld(up_ack_vld), .up_ack_rdy(up_ack_rdy),
        .up_rd_data(up_rd_data),
`ifdef REG_NATIVE_ARB_TIMEOUT_EN
        .up_err(up_err),
`endif
        .req_vld(req_vld), .req_rdy(req_rdy),
        .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wr_data(wr_data),
        .ack_vld(ack_vld), .ack_rdy(ack_rdy), .rd_data(rd_data),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    // Handshake observer: counts transfers and acts as the downstream register for writes.
    always @(negedge clk) begin
        if (req_vld && req_rdy) begin
            ds_req_cnt++;
            if (wr_en) mreg = wr_data;
        end
        if ((up_ack_vld & up_ack_rdy) != 2'b00) up_ack_cnt++;
        if (up_ack_vld[1]) ack1_seen = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Zero-wait transaction; the caller sets up_req_vld and payload, with req_rdy/ack_vld/up_ack_rdy high.
    task automatic run_txn(input logic [31:0] rdv, output logic [1:0] rdy0, output logic req1,
                           output logic [0:0] g1, output logic [31:0] wd1,
                           output logic [1:0] ack3, output logic [31:0] rd3);
        rd_data = rdv;
        #1;
        rdy0 = up_req_rdy;
        tick();
        req1 = req_vld; g1 = grant_id; wd1 = wr_data;
        tick();
        tick();
        ack3 = up_ack_vld; rd3 = up_rd_data;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if ({busy, req_vld, ack_rdy, wr_en, rd_en} !== 5'b00000) begin n_fail++; $display("FAIL reset_ctrl: got %b required 00000", {busy, req_vld, ack_rdy, wr_en, rd_en}); end
        n_chk++; if ({up_ack_vld, up_req_rdy, grant_id} !== 5'b00000) begin n_fail++; $display("FAIL reset_up: got %b required 00000", {up_ack_vld, up_req_rdy, grant_id}); end
        n_chk++; if ({addr, wr_data, up_rd_data} !== 128'h0) begin n_fail++; $display("FAIL reset_data: got %h required 0", {addr, wr_data, up_rd_data}); end
    endtask

    task automatic test_single_read();
        logic [1:0] rdy0, ack3; logic req1; logic [0:0] g1; logic [31:0] wd1, rd3;
        ack1_seen = 1'b0;
        up_wr_en = 2'b00; up_rd_en = 2'b01; up_addr = '0; up_req_vld = 2'b01;
        run_txn(32'hA5A5A5A5, rdy0, req1, g1, wd1, ack3, rd3);
        up_req_vld = 2'b00;
        n_chk++; if (rdy0 !== 2'b01) begin n_fail++; $display("FAIL single_rdy: got %b required 01", rdy0); end
        n_chk++; if (req1 !== 1'b1) begin n_fail++; $display("FAIL single_req_vld_c1: got %b required 1", req1); end
        n_chk++; if (ack3 !== 2'b01) begin n_fail++; $display("FAIL single_ack_c3: got %b required 01", ack3); end
        n_chk++; if (rd3 !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL single_rd_data: got %h required a5a5a5a5", rd3); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_c4: got busy %b required 0", busy); end
        n_chk++; if (ack1_seen !== 1'b0) begin n_fail++; $display("FAIL single_no_ack1: got %b required 0", ack1_seen); end
    endtask

    task automatic test_round_robin();
        logic [1:0] rdy0, ack3; logic req1; logic [0:0] g1; logic [31:0] wd1, rd3;
        logic [0:0]  exp_g [3];
        logic [31:0] exp_wd [3];
        exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0;
        exp_wd[0] = 32'h11111111; exp_wd[1] = 32'h22222222; exp_wd[2] = 32'h11111111;
        do_reset();
        up_wr_en = 2'b11; up_rd_en = 2'b00;
        up_wr_data = {32'h22222222, 32'h11111111};
        up_req_vld = 2'b11;
        for (int t = 0; t < 3; t++) begin
            run_txn(32'h0, rdy0, req1, g1, wd1, ack3, rd3);
            n_chk++; if (g1 !== exp_g[t]) begin n_fail++; $display("FAIL rr_grant%0d: got %0d required %0d", t, g1, exp_g[t]); end
            n_chk++; if (wd1 !== exp_wd[t]) begin n_fail++; $display("FAIL rr_wdata%0d: got %h required %h", t, wd1, exp_wd[t]); end
            n_chk++; if (rdy0 !== (2'b01 << exp_g[t])) begin n_fail++; $display("FAIL rr_rdy%0d: got %b", t, rdy0); end
        end
        up_req_vld = 2'b00;
    endtask

    task automatic test_backpressure();
        req_rdy = 1'b0; ack_vld = 1'b1; up_ack_rdy = 2'b00; rd_data = 32'hDEADBEEF;
        up_wr_en = 2'b01; up_rd_en = 2'b00;
        up_addr[63:0] = 64'h40; up_wr_data[31:0] = 32'h33333333;
        ds_req_cnt = 0; up_ack_cnt = 0;
        up_req_vld = 2'b01;
        tick();
        up_req_vld = 2'b00;
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if ({req_vld, busy, ack_rdy, addr, wr_data} !== {1'b1, 1'b1, 1'b0, 64'h40, 32'h33333333}) begin
                n_fail++; $display("FAIL bp_req_hold%0d: got vld %b busy %b ack_rdy %b addr %h wdata %h", i, req_vld, busy, ack_rdy, addr, wr_data);
            end
            tick();
        end
        req_rdy = 1'b1;
        tick();
        req_rdy = 1'b0;
        n_chk++; if ({ack_rdy, up_ack_vld} !== 3'b100) begin n_fail++; $display("FAIL bp_wait_ack: got %b required 100", {ack_rdy, up_ack_vld}); end
        tick();
        ack_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if ({up_ack_vld, busy, up_rd_data} !== {2'b01, 1'b1, 32'hDEADBEEF}) begin
                n_fail++; $display("FAIL bp_resp_hold%0d: got ack %b busy %b data %h", i, up_ack_vld, busy, up_rd_data);
            end
            tick();
        end
        up_ack_rdy = 2'b01;
        tick();
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got busy %b required 0", busy); end
        n_chk++; if (ds_req_cnt !== 1) begin n_fail++; $display("FAIL bp_ds_count: got %0d required 1", ds_req_cnt); end
        n_chk++; if (up_ack_cnt !== 1) begin n_fail++; $display("FAIL bp_up_count: got %0d required 1", up_ack_cnt); end
        up_ack_rdy = 2'b11; req_rdy = 1'b1; ack_vld = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [1:0] rdy0, ack3; logic req1; logic [0:0] g1; logic [31:0] wd1, rd3;
        ack_vld = 1'b0; req_rdy = 1'b1;
        up_wr_en = 2'b00; up_rd_en = 2'b01; up_req_vld = 2'b01;
        tick();
        up_req_vld = 2'b00;
        tick();
        n_chk++; if (ack_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_wait: got ack_rdy %b required 1", ack_rdy); end
        rst = 1'b1;
        #1;
        n_chk++; if ({busy, req_vld, ack_rdy, wr_en, rd_en, up_ack_vld, grant_id} !== 8'h00) begin n_fail++; $display("FAIL rst_mid_ctrl: got %b required 0", {busy, req_vld, ack_rdy, wr_en, rd_en, up_ack_vld, grant_id}); end
        n_chk++; if ({addr, wr_data, up_rd_data} !== 128'h0) begin n_fail++; $display("FAIL rst_mid_data: got %h required 0", {addr, wr_data, up_rd_data}); end
        ack_vld = 1'b1;
        up_ack_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        up_rd_en = 2'b11; up_req_vld = 2'b11;
        run_txn(32'hCAFEF00D, rdy0, req1, g1, wd1, ack3, rd3);
        n_chk++; if (rdy0 !== 2'b01) begin n_fail++; $display("FAIL rst_first_pick: got %b required 01", rdy0); end
        n_chk++; if (ack3 !== 2'b01 || rd3 !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rst_txn0: got ack %b data %h required 01 cafef00d", ack3, rd3); end
        up_req_vld = 2'b10;
        run_txn(32'h0BADF00D, rdy0, req1, g1, wd1, ack3, rd3);
        up_req_vld = 2'b00;
        n_chk++; if (ack3 !== 2'b10 || rd3 !== 32'h0BADF00D) begin n_fail++; $display("FAIL rst_txn1: got ack %b data %h required 10 0badf00d", ack3, rd3); end
        n_chk++; if (up_ack_cnt !== 2) begin n_fail++; $display("FAIL rst_no_abort_ack: got %0d acks required 2", up_ack_cnt); end
    endtask

    task automatic test_rw_mix();
        logic [1:0] rdy0, ack3; logic req1; logic [0:0] g1; logic [31:0] wd1, rd3;
        up_wr_en = 2'b10; up_rd_en = 2'b00;
        up_addr[127:64] = 64'h100; up_wr_data[63:32] = 32'h12345678;
        up_req_vld = 2'b10;
        run_txn(32'h0, rdy0, req1, g1, wd1, ack3, rd3);
        up_req_vld = 2'b00;
        n_chk++; if (rdy0 !== 2'b10 || wd1 !== 32'h12345678) begin n_fail++; $display("FAIL mix_write: got rdy %b wdata %h required 10 12345678", rdy0, wd1); end
        up_wr_en = 2'b00; up_rd_en = 2'b01; up_addr[63:0] = 64'h100;
        up_req_vld = 2'b01;
        run_txn(mreg, rdy0, req1, g1, wd1, ack3, rd3);
        up_req_vld = 2'b00;
        n_chk++; if (ack3 !== 2'b01 || rd3 !== 32'h12345678) begin n_fail++; $display("FAIL mix_read: got ack %b data %h required 01 12345678", ack3, rd3); end
    endtask

`ifdef REG_NATIVE_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        do_reset();
        req_rdy = 1'b1; ack_vld = 1'b0; up_ack_rdy = 2'b11;
        up_wr_en = 2'b00; up_rd_en = 2'b01; up_req_vld = 2'b01;
        tick();
        up_req_vld = 2'b00;
        n = 0;
        while (up_ack_vld == 2'b00 && n < 40) begin
            tick();
            n++;
        end
        n_chk++; if (n !== 16) begin n_fail++; $display("FAIL to_latency: got %0d cycles required 16", n); end
        n_chk++; if (up_rd_data !== 32'hFFFFFFFF || up_err !== 1'b1) begin n_fail++; $display("FAIL to_resp: got data %h err %b required ffffffff 1", up_rd_data, up_err); end
        tick();
        n_chk++; if (up_err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL to_clear: got err %b busy %b required 0 0", up_err, busy); end
        ack_vld = 1'b1;
    endtask
`endif

    initial begin
        rst = 1'b1;
        up_req_vld = '0; up_wr_en = '0; up_rd_en = '0; up_addr = '0; up_wr_data = '0;
        up_ack_rdy = 2'b11; req_rdy = 1'b1; ack_vld = 1'b1; rd_data = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_rw_mix();
`ifdef REG_NATIVE_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_native_arb.md
# reg_native_arb

Round-robin arbiter that shares one downstream `reg_native_if` (a regslv or external memory port) between `N_REQ` upstream masters, e.g. the APB-driven regmst and a hardware debug/scan master. It accepts one transaction at a time and forwards it downstream. It then returns the acknowledge and read data to the granted requester only. The block sits between the regmst `ext_*` port group and a regslv `req_*`/`ack_*` port group.

## Interface
- `N_REQ`, 2: number of upstream requesters (2..8).
- `ADDR_WIDTH`, 64: address width.
- `DATA_WIDTH`, 32: data width.
- `TIMEOUT_CYCLES`, 255: downstream cycle budget. Used only when `REG_NATIVE_ARB_TIMEOUT_EN` is defined.
- `clk`  in  1  single clock for the block.
- `rst`  in  1  reset, asynchronous and active-high.
- `up_req_vld`  in  N_REQ  per-requester request valid.
- `up_req_rdy`  out  N_REQ  per-requester request accepted (one-hot pulse).
- `up_wr_en` / `up_rd_en`  in  N_REQ  per-requester write / read strobe.
- `up_addr`  in  N_REQ×ADDR_WIDTH  per-requester address.
- `up_wr_data`  in  N_REQ×DATA_WIDTH  per-requester write data.
- `up_ack_vld`  out  N_REQ  per-requester acknowledge (one-hot).
- `up_ack_rdy`  in  N_REQ  per-requester acknowledge ready.
- `up_rd_data`  out  DATA_WIDTH  shared read data; valid with `up_ack_vld`.
- `up_err`  out  1  timeout flag, qualified by `up_ack_vld`. Present only with the macro.
- `req_vld` / `req_rdy`  out / in  1  downstream request handshake.
- `wr_en`, `rd_en`, `addr`, `wr_data`  out  1, 1, ADDR_WIDTH, DATA_WIDTH  downstream request payload.
- `ack_vld` / `ack_rdy`  in / out  1  downstream acknowledge handshake.
- `rd_data`  in  DATA_WIDTH  downstream read data.
- `grant_id`  out  clog2(N_REQ)  index of the current or last granted requester.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- The FSM has four states: IDLE, REQ, WAIT_ACK and RESP.
- **IDLE**
  - If any `up_req_vld` is high, pick a winner by round-robin.
  - Search starts at `rr_ptr+1`, modulo N_REQ.
  - In the same cycle, pulse `up_req_rdy[winner]` for one cycle.
  - Register `wr_en`, `rd_en`, `addr` and `wr_data` from the winner.
  - Set `grant_id` and `rr_ptr` to the winner, then go to REQ.
- **REQ**
  - Hold `req_vld=1` with a stable payload.
  - On `req_vld && req_rdy`, go to WAIT_ACK.
- **WAIT_ACK**
  - Hold `ack_rdy=1`.
  - On `ack_vld`, capture `rd_data` into `up_rd_data` and go to RESP.
  - For writes, `up_rd_data` takes the captured value unchanged.
  - If `ack_vld` arrives while still in REQ (the same cycle as `req_rdy`), it is not consumed. `ack_rdy` stays low in REQ.
- **RESP**
  - Drive `up_ack_vld[grant_id]=1` and hold `up_rd_data`.
  - On `up_ack_rdy[grant_id]`, go to IDLE.
- Requests from non-granted masters are held off: their `up_req_rdy` stays 0 until the arbiter returns to IDLE.
- A request with both `up_wr_en` and `up_rd_en` set is forwarded unchanged. Decoding that case belongs to the downstream block.
- Reset values:
  - State is IDLE.
  - `rr_ptr = N_REQ-1`, so requester 0 wins first.
  - `grant_id=0`, `busy=0`.
  - All handshake outputs are 0.
  - `addr`, `wr_data` and `up_rd_data` are 0.
  - `up_err=0`.
- Reset asserted mid-transaction returns the FSM to IDLE immediately. No ack is issued for the aborted transaction.

## Timing
- Minimum transaction with zero-wait downstream and upstream:
  - Cycle 0: IDLE accept.
  - Cycle 1: REQ handshake.
  - Cycle 2: WAIT_ACK with `ack_vld`.
  - Cycle 3: RESP handshake.
  - Back in IDLE at cycle 4, ready for the next arbitration.
- All outputs are registered or decoded from state only. There is no combinational path from `up_*` inputs to downstream outputs.
- `up_req_rdy` depends combinationally on `up_req_vld` and the state.
- Simultaneous requests resolve one per transaction in rotating order. A requester that holds `up_req_vld` waits at most N_REQ-1 transactions.

## Configuration
- `REG_NATIVE_ARB_TIMEOUT_EN` defined:
  - An 8..16-bit counter clears on leaving IDLE and counts while in REQ or WAIT_ACK.
  - When the count reaches `TIMEOUT_CYCLES`, the FSM drops `req_vld`/`ack_rdy` and goes to RESP.
  - In that RESP, `up_rd_data` is all ones and `up_err=1`.
  - `up_err` clears on leaving RESP.
- Not defined: there is no counter and no `up_err` port. The FSM waits indefinitely in REQ and WAIT_ACK.

## Test plan
- **Single read, requester 0:** `addr=0x0`, `rd_data=0xA5A5A5A5`, zero-wait. Expect `req_vld` at cycle 1, `up_ack_vld[0]` at cycle 3, `up_rd_data=0xA5A5A5A5`, `up_ack_vld[1]` never set.
- **Simultaneous writes from requesters 0 and 1, held for three transactions:** grants go 0, 1, 0. The downstream sees `wr_data` 0x11111111, 0x22222222, 0x11111111 in that order.
- **Backpressure:** `req_rdy` low for 5 cycles and `up_ack_rdy` low for 3 cycles. The payload stays stable and `busy=1` throughout. Exactly one downstream request and one upstream ack occur.
- **Reset in WAIT_ACK:** assert `rst` for 1 cycle. All outputs return to their reset values, the next request from requester 1 completes normally, and requester 0 remains the first pick after reset.
- **Timeout (macro defined, `TIMEOUT_CYCLES=16`, `ack_vld` never asserted):** `up_ack_vld` asserts 16 cycles after REQ entry, with `up_rd_data=0xFFFFFFFF` and `up_err=1`.
- **Read/write mix to the hw=rw register:** write `0x12345678` from requester 1, then read from requester 0. The read returns `0x12345678`.
